// File: rtl/matrix_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_ram_loader
//  Purpose  : Host-side front/back end for matrix_mul_cu. Loads a header,
//             matrix A and matrix B from an input stream into the shared RAM,
//             kicks the CU, then streams the result region back out.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_ram_loader #(
    parameter int DATA_W    = 32,
    parameter int RAM_D     = 512,
    parameter int RAM_ADD_W = $clog2(RAM_D),
    parameter int D_W_Q     = DATA_W / 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 ram_sel,
    output logic                 ram_we,
    output logic [RAM_ADD_W-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_w_data,
    input  logic [DATA_W-1:0]    ram_r_data,
    output logic                 cu_start,
    input  logic                 cu_done,
    input  logic                 cu_err,
    output logic                 busy,
    output logic                 err
);

    localparam int c_prod_w = 2 * D_W_Q;
    localparam int c_sum_w  = c_prod_w + 2;
    localparam logic [c_sum_w-1:0]   c_ram_d    = c_sum_w'(RAM_D);
    localparam logic [RAM_ADD_W-1:0] c_last_adr = RAM_ADD_W'(RAM_D - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_hdr   = 3'd1;
    localparam logic [2:0] c_st_load  = 3'd2;
    localparam logic [2:0] c_st_start = 3'd3;
    localparam logic [2:0] c_st_run   = 3'd4;
    localparam logic [2:0] c_st_read  = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;

    // header fields and derived sizes
    logic [D_W_Q-1:0]     r_m1, r_n1, r_m2, r_n2;
    logic [RAM_ADD_W-1:0] r_n_load;
    logic [RAM_ADD_W-1:0] r_n_c;
    logic [RAM_ADD_W-1:0] r_idx;
    logic                 r_load_done;
    logic                 r_err;

    // registered RAM write port
    logic                 r_ram_we;
    logic [RAM_ADD_W-1:0] r_ram_addr;
    logic [DATA_W-1:0]    r_ram_w_data;

    // read-out pipeline
    logic [RAM_ADD_W-1:0] r_rd_issued;
    logic                 r_rd_pend;
    logic [DATA_W-1:0]    r_m_data;
    logic                 r_m_valid;
    logic [DATA_W-1:0]    r_skid_data;
    logic                 r_skid_valid;
    logic [RAM_ADD_W-1:0] r_out_cnt;

    logic                 w_s_ready;
    logic                 w_ram_sel;
    logic                 w_cu_start;
    logic                 w_busy;
    logic                 w_accept;
    logic [c_prod_w-1:0]  w_na, w_nb, w_nc;
    logic [c_sum_w-1:0]   w_total;
    logic                 w_cfg_bad;
    logic                 w_pop;
    logic                 w_last_out;
    logic [1:0]           w_occ;
    logic                 w_issue;
    logic [RAM_ADD_W-1:0] w_rd_addr;

    assign w_accept = s_valid && w_s_ready;

    // Products are formed at full width so oversized headers cannot wrap past the check
    assign w_na    = c_prod_w'(r_m1) * c_prod_w'(r_n1);
    assign w_nb    = c_prod_w'(r_m2) * c_prod_w'(r_n2);
    assign w_nc    = c_prod_w'(r_m1) * c_prod_w'(r_n2);
    assign w_total = c_sum_w'(2) + c_sum_w'(w_na) + c_sum_w'(w_nb) + c_sum_w'(w_nc);
    assign w_cfg_bad = (r_m1 == '0) || (r_n1 == '0) || (r_m2 == '0) || (r_n2 == '0) ||
                       (r_n1 != r_m2) || (w_total > c_ram_d);

    // Read pipeline: an issue is allowed only if its data is guaranteed a slot
    // (output register or skid) even if the sink stalls from now on.
    assign w_pop      = r_m_valid && m_ready;
    assign w_last_out = (r_out_cnt == (r_n_c - RAM_ADD_W'(1)));
    assign w_occ      = 2'(r_m_valid) + 2'(r_skid_valid) + 2'(r_rd_pend);
    assign w_issue    = (r_state == c_st_read) && (r_rd_issued != r_n_c) &&
                        ((w_occ - 2'(w_pop)) <= 2'd1);
    assign w_rd_addr  = c_last_adr - r_rd_issued;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_nxt = c_st_hdr;
            c_st_hdr:   w_state_nxt = w_cfg_bad ? c_st_idle : c_st_load;
            c_st_load:  if (r_load_done) w_state_nxt = c_st_start;
            c_st_start: w_state_nxt = c_st_run;
            c_st_run: begin
                if (cu_err) begin
                    w_state_nxt = c_st_idle;
                end else if (cu_done) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read:  if (w_pop && w_last_out) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // State-decoded outputs; LOAD spends one extra cycle (s_ready low) while the last word is written
    always_comb begin
        w_s_ready  = 1'b0;
        w_ram_sel  = 1'b1;
        w_cu_start = 1'b0;
        w_busy     = (r_state != c_st_idle);
        case (r_state)
            c_st_idle:  w_s_ready = 1'b1;
            c_st_load:  w_s_ready = !r_load_done;
            c_st_start: begin
                w_ram_sel  = 1'b0;
                w_cu_start = 1'b1;
            end
            c_st_run:   w_ram_sel = 1'b0;
            default:    ;
        endcase
    end

    // Header capture, RAM write port and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m1         <= '0;
            r_n1         <= '0;
            r_m2         <= '0;
            r_n2         <= '0;
            r_n_load     <= '0;
            r_n_c        <= '0;
            r_idx        <= '0;
            r_load_done  <= 1'b0;
            r_err        <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_w_data <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_m1         <= s_data[DATA_W-1 -: D_W_Q];
                        r_n1         <= s_data[DATA_W-D_W_Q-1 -: D_W_Q];
                        r_m2         <= s_data[2*D_W_Q-1 -: D_W_Q];
                        r_n2         <= s_data[D_W_Q-1:0];
                        r_err        <= 1'b0;
                        r_ram_we     <= 1'b1;
                        r_ram_addr   <= '0;
                        r_ram_w_data <= s_data;
                    end
                end
                c_st_hdr: begin
                    r_ram_we     <= 1'b1;
                    r_ram_addr   <= RAM_ADD_W'(1);
                    r_ram_w_data <= '0;
                    r_n_load     <= RAM_ADD_W'(w_na + w_nb);
                    r_n_c        <= RAM_ADD_W'(w_nc);
                    r_idx        <= '0;
                    r_load_done  <= 1'b0;
                    if (w_cfg_bad) begin
                        r_err <= 1'b1;
                    end
                end
                c_st_load: begin
                    if (r_load_done) begin
                        r_ram_addr   <= '0;
                        r_ram_w_data <= '0;
                    end else if (w_accept) begin
                        r_ram_we     <= 1'b1;
                        r_ram_addr   <= r_idx + RAM_ADD_W'(2);
                        r_ram_w_data <= s_data;
                        r_idx        <= r_idx + RAM_ADD_W'(1);
                        if (r_idx == (r_n_load - RAM_ADD_W'(1))) begin
                            r_load_done <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    if (cu_err) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result read-out: address issue, one-cycle RAM latency, output register plus skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_issued  <= '0;
            r_rd_pend    <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            case (r_state)
                c_st_start: begin
                    r_rd_issued  <= '0;
                    r_rd_pend    <= 1'b0;
                    r_m_valid    <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_out_cnt    <= '0;
                end
                c_st_read: begin
                    r_rd_pend <= w_issue;
                    if (w_issue) begin
                        r_rd_issued <= r_rd_issued + RAM_ADD_W'(1);
                    end
                    if (w_pop) begin
                        r_out_cnt <= r_out_cnt + RAM_ADD_W'(1);
                        if (r_skid_valid) begin
                            r_m_data     <= r_skid_data;
                            r_m_valid    <= 1'b1;
                            r_skid_valid <= r_rd_pend;
                            if (r_rd_pend) begin
                                r_skid_data <= ram_r_data;
                            end
                        end else begin
                            r_m_valid <= r_rd_pend;
                            if (r_rd_pend) begin
                                r_m_data <= ram_r_data;
                            end
                        end
                        if (w_last_out) begin
                            r_m_valid <= 1'b0;
                        end
                    end else if (!r_m_valid) begin
                        r_m_valid <= r_rd_pend;
                        if (r_rd_pend) begin
                            r_m_data <= ram_r_data;
                        end
                    end else if (r_rd_pend) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= ram_r_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready    = w_s_ready;
    assign ram_sel    = w_ram_sel;
    assign cu_start   = w_cu_start;
    assign busy       = w_busy;
    assign err        = r_err;
    assign ram_we     = r_ram_we;
    assign ram_w_data = r_ram_w_data;
    assign ram_addr   = (r_state == c_st_read) ? w_rd_addr : r_ram_addr;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_valid && w_last_out;

endmodule
`default_nettype wire
